vend_dispense_unit: RTL and testbench
=====================================

# vend_dispense_unit

Mechanism-side endpoint of the vending controller's dispense interface. Accepts the controller's one-hot `motor_control` request, runs the selected spiral motor for a fixed time, confirms the drop on the optical sensor, and returns `item_dispensed` to close the handshake. It also keeps a per-slot stock count that drives the `out_of_stock` flags read by the controller, and raises a latched jam fault when no drop is seen.

## Interface
- `MOTOR_ON_CYCLES`, default 1000: number of cycles the motor is driven per vend.
- `SENSE_TIMEOUT`, default 4000: cycles allowed after motor-off for the drop to be seen.
- `STOCK_W`, default 4: width of each slot's stock counter.
- `STOCK_INIT`, default 8: stock value loaded into every slot at reset.

- `clk` in 1: system clock.
- `reset` in 1: reset; asynchronous, active-high.
- `motor_control` in 4: one-hot vend request from the controller, held for the whole vend.
- `drop_sensor` in 1: beam-break sensor, asynchronous; 1 means the beam is broken.
- `restock_load` in 1: one-cycle strobe that loads `restock_count` into slot `restock_slot`.
- `restock_slot` in 2: slot index for a restock.
- `restock_count` in STOCK_W: new stock value.
- `motor_drive` out 4: one-hot motor enable to the power stage.
- `item_dispensed` out 1: drop confirmed; held until the request is withdrawn.
- `out_of_stock` out 4: bit i is 1 when stock[i] is 0.
- `jam_fault` out 1: latched fault, no drop seen.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, WAIT_DROP, DONE, FAULT.
- **IDLE**
  - A vend is accepted only when `motor_control` has exactly one bit set and that slot's stock is not 0.
  - On acceptance, latch the slot index, clear the timer, and go to RUN.
  - Zero, multi-hot, or empty-slot requests are ignored and the FSM stays in IDLE.
- **RUN**
  - `motor_drive` = one-hot of the latched slot; the timer counts up.
  - A sensor rising edge goes to DONE and the motor stops immediately.
  - After MOTOR_ON_CYCLES cycles the motor turns off, the timer clears, and the FSM goes to WAIT_DROP.
- **WAIT_DROP**
  - Motor is off.
  - A sensor rising edge goes to DONE.
  - After SENSE_TIMEOUT cycles with no edge, go to FAULT.
- **DONE**
  - `item_dispensed` = 1.
  - The latched slot's stock decrements once, on entry; it is never decremented below 0.
  - Return to IDLE in the cycle after `motor_control` is sampled as 0. While `motor_control` stays nonzero, the FSM stays in DONE with no re-vend.
- **FAULT**
  - `jam_fault` = 1, motor off, `busy` = 1.
  - New requests are ignored. The only exit is `reset`.
- **Request withdrawn mid-vend:** if `motor_control` drops to 0 in RUN or WAIT_DROP, the vend is not aborted. The FSM completes normally and, because the request is already 0, DONE lasts one cycle.
- **Sensor path:** 2-flop synchronizer followed by a rising-edge detector. Edges seen in IDLE, DONE or FAULT are discarded.
- **Restock**
  - Allowed in any state.
  - Loads the slot's counter directly; the value is not added to the old count.
  - If it coincides with the DONE decrement of the same slot, the load wins.
  - Restocking does not clear FAULT.
- **Timer:** one shared counter of width clog2(max(MOTOR_ON_CYCLES, SENSE_TIMEOUT)+1). It clears on every state change.

## Timing
- **Reset values:**
  - State IDLE.
  - `motor_drive` = 0, `item_dispensed` = 0, `jam_fault` = 0, `busy` = 0.
  - Every stock counter = STOCK_INIT, so `out_of_stock` = 0 when STOCK_INIT > 0.
  - Synchronizer flops = 0.
- All outputs are registered.
- `motor_drive` and `busy` rise 1 cycle after the cycle in which a valid request is sampled in IDLE.
- Drop latency: sensor pin change to `item_dispensed` rising is 3 cycles (2 synchronizer cycles plus the edge/state register).
- `motor_drive` is 1 for exactly MOTOR_ON_CYCLES cycles unless the drop arrives first.
- `out_of_stock` updates 1 cycle after a stock change: after the DONE decrement, or after a restock load.
- `jam_fault` rises at cycle 1 + MOTOR_ON_CYCLES + SENSE_TIMEOUT after acceptance.
- After `motor_control` returns to 0, `item_dispensed` falls within 1 cycle and `busy` falls with it.

## Test plan
- **Normal vend:** `motor_control`=4'b0100, sensor pulse 200 cycles after acceptance, request cleared 2 cycles after `item_dispensed`.
  - `motor_drive`=4'b0100 for 200+2 cycles.
  - `item_dispensed` high until the request clears.
  - stock[2] goes 8→7; `busy` returns to 0.
- **Late drop:** sensor pulse 50 cycles after motor-off.
  - `motor_drive` is high for exactly 1000 cycles.
  - DONE is reached with no fault.
- **Jam:** no sensor activity.
  - `jam_fault`=1 at 1+1000+4000 cycles, motor off.
  - A new request is ignored; `reset` clears the fault.
- **Empty slot:** restock slot 1 to 1, vend slot 1 once.
  - `out_of_stock`=4'b0010 after the vend.
  - A second request for slot 1 leaves `busy`=0 and `motor_drive`=0.
- **Illegal requests:** `motor_control`=4'b0110 and `motor_control`=0.
  - No acceptance.
  - Sensor glitches while in IDLE produce no `item_dispensed`.
- **Race cases:**
  - A restock load of slot 0 to 5 in the same cycle as the slot 0 DONE decrement leaves stock[0]=5.
  - `reset` asserted mid-RUN turns the motor off asynchronously and returns all stock counters to 8.

Source files
------------

// File: rtl/vend_dispense_unit.sv
// Mechanism-side dispense endpoint: runs the selected spiral motor, confirms the drop on the
// beam-break sensor, tracks per-slot stock and latches a jam fault when no drop is seen.
module vend_dispense_unit #(
    parameter int unsigned MOTOR_ON_CYCLES = 1000,
    parameter int unsigned SENSE_TIMEOUT   = 4000,
    parameter int unsigned STOCK_W         = 4,
    parameter int unsigned STOCK_INIT      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         motor_control,
    input  logic               drop_sensor,
    input  logic               restock_load,
    input  logic [1:0]         restock_slot,
    input  logic [STOCK_W-1:0] restock_count,
    output logic [3:0]         motor_drive,
    output logic               item_dispensed,
    output logic [3:0]         out_of_stock,
    output logic               jam_fault,
    output logic               busy
);

    localparam int unsigned TIMER_MAX =
        (MOTOR_ON_CYCLES > SENSE_TIMEOUT) ? MOTOR_ON_CYCLES : SENSE_TIMEOUT;
    localparam int unsigned TIMER_W = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] RUN_LAST  = TIMER_W'(MOTOR_ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(SENSE_TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StWaitDrop,
        StDone,
        StFault
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           slot_q, slot_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [STOCK_W-1:0]   stock_q [4];
    logic [STOCK_W-1:0]   stock_d [4];
    logic [3:0]           out_of_stock_d;
    logic                 sense_meta_q, sense_sync_q, sense_prev_q;
    logic                 sense_rise;
    logic                 req_valid;
    logic [1:0]           req_slot;

    assign sense_rise = sense_sync_q & ~sense_prev_q;

    always_comb begin
        req_slot = '0;
        for (int i = 0; i < 4; i++) begin
            if (motor_control[i]) begin
                req_slot = 2'(i);
            end
        end
        req_valid = $onehot(motor_control) && (stock_q[req_slot] != '0);
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StRun;
                    slot_d  = req_slot;
                end
            end
            StRun: begin
                if (sense_rise) begin
                    state_d = StDone;
                end else if (timer_q == RUN_LAST) begin
                    state_d = StWaitDrop;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StWaitDrop: begin
                if (sense_rise) begin
                    state_d = StDone;
                end else if (timer_q == WAIT_LAST) begin
                    state_d = StFault;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StDone: begin
                if (motor_control == 4'b0000) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Decrement on the edge that enters DONE; a coincident restock load overrides it.
    always_comb begin
        stock_d = stock_q;
        if ((state_d == StDone) && (state_q != StDone) && (stock_q[slot_q] != '0)) begin
            stock_d[slot_q] = stock_q[slot_q] - STOCK_W'(1);
        end
        if (restock_load) begin
            stock_d[restock_slot] = restock_count;
        end
        for (int i = 0; i < 4; i++) begin
            out_of_stock_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            slot_q         <= '0;
            timer_q        <= '0;
            sense_meta_q   <= 1'b0;
            sense_sync_q   <= 1'b0;
            sense_prev_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_RST;
            end
            motor_drive    <= 4'b0000;
            item_dispensed <= 1'b0;
            out_of_stock   <= {4{STOCK_RST == '0}};
            jam_fault      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            timer_q        <= timer_d;
            sense_meta_q   <= drop_sensor;
            sense_sync_q   <= sense_meta_q;
            sense_prev_q   <= sense_sync_q;
            stock_q        <= stock_d;
            motor_drive    <= (state_d == StRun) ? (4'(1) << slot_d) : 4'b0000;
            item_dispensed <= (state_d == StDone);
            out_of_stock   <= out_of_stock_d;
            jam_fault      <= (state_d == StFault);
            busy           <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_vend_dispense_unit.sv
// Self-checking bench for vend_dispense_unit: vector table of vends/ignored requests with a
// scoreboard queue, plus hand sequences for restock race, jam fault and reset mid-run.
module tb_vend_dispense_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] motor_control;
    logic       drop_sensor;
    logic       restock_load;
    logic [1:0] restock_slot;
    logic [3:0] restock_count;
    logic [3:0] motor_drive;
    logic       item_dispensed;
    logic [3:0] out_of_stock;
    logic       jam_fault;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    vend_dispense_unit #(
        .MOTOR_ON_CYCLES(1000),
        .SENSE_TIMEOUT  (4000),
        .STOCK_W        (4),
        .STOCK_INIT     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .motor_control (motor_control),
        .drop_sensor   (drop_sensor),
        .restock_load  (restock_load),
        .restock_slot  (restock_slot),
        .restock_count (restock_count),
        .motor_drive   (motor_drive),
        .item_dispensed(item_dispensed),
        .out_of_stock  (out_of_stock),
        .jam_fault     (jam_fault),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mc;
        int         k;
        int         budget;
        logic       accept;
        int         exp_drive;
        logic [3:0] exp_oos;
        logic       pre_rs;
        logic [1:0] rs_slot;
        logic [3:0] rs_cnt;
        string      name;
    } vec_t;

    typedef struct {
        int         drive;
        logic [3:0] oos;
        logic       disp;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_restock(input logic [1:0] slot, input logic [3:0] cnt);
        restock_slot  = slot;
        restock_count = cnt;
        restock_load  = 1'b1;
        tick();
        restock_load  = 1'b0;
    endtask

    // Sensor goes high k edges after the accepting edge; restock strobe optionally at step rs_at.
    task automatic run_vend(input string name, input logic [3:0] mc, input int k,
                            input int budget, input int exp_drive, input logic [3:0] exp_oos,
                            input int rs_at, input logic [1:0] rs_slot, input logic [3:0] rs_cnt);
        int   drive_cnt = 0;
        logic got       = 1'b0;
        logic bad_drive = 1'b0;
        exp_t e;
        sb.push_back('{exp_drive, exp_oos, 1'b1, name});
        motor_control = mc;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (n == k + 1) drop_sensor = 1'b1;
            if (n == k + 4) drop_sensor = 1'b0;
            if (n == rs_at) begin
                restock_slot  = rs_slot;
                restock_count = rs_cnt;
                restock_load  = 1'b1;
            end
            if (n == rs_at + 1) restock_load = 1'b0;
            if (motor_drive == mc) drive_cnt++;
            else if (motor_drive != 4'b0000) bad_drive = 1'b1;
            if (item_dispensed) begin
                got = 1'b1;
                break;
            end
        end
        drop_sensor  = 1'b0;
        restock_load = 1'b0;
        e = sb.pop_front();
        check({e.name, " dispensed"}, int'(got), int'(e.disp));
        check({e.name, " drive cycles"}, drive_cnt, e.drive);
        check({e.name, " drive one-hot"}, int'(bad_drive), 0);
        check({e.name, " no jam"}, int'(jam_fault), 0);
        if (got) begin
            repeat (2) tick();
            check({e.name, " dispensed held"}, int'(item_dispensed), 1);
            check({e.name, " no re-vend"}, int'(motor_drive), 0);
            motor_control = 4'b0000;
            tick();
            check({e.name, " dispensed cleared"}, int'(item_dispensed), 0);
            check({e.name, " busy cleared"}, int'(busy), 0);
        end
        motor_control = 4'b0000;
        tick();
        check({e.name, " out_of_stock"}, int'(out_of_stock), int'(e.oos));
    endtask

    task automatic run_ignored(input string name, input logic [3:0] mc, input int k,
                               input int cycles);
        logic seen = 1'b0;
        motor_control = mc;
        for (int n = 1; n <= cycles; n++) begin
            tick();
            drop_sensor = (n > k) && (n <= k + 2);
            if (busy || item_dispensed || (motor_drive != 4'b0000)) seen = 1'b1;
        end
        drop_sensor   = 1'b0;
        motor_control = 4'b0000;
        tick();
        check({name, " not accepted"}, int'(seen), 0);
    endtask

    initial begin
        int jam_n;
        int jam_drive;

        tbl[0] = '{4'b0100, 199,  400,  1'b1, 202,  4'b0000, 1'b0, 2'd0, 4'd0, "normal"};
        tbl[1] = '{4'b0001, 1050, 1200, 1'b1, 1000, 4'b0000, 1'b0, 2'd0, 4'd0, "late_drop"};
        tbl[2] = '{4'b0010, 5,    50,   1'b1, 8,    4'b0010, 1'b1, 2'd1, 4'd1, "last_item"};
        tbl[3] = '{4'b0010, 3,    20,   1'b0, 0,    4'b0010, 1'b0, 2'd0, 4'd0, "empty_slot"};
        tbl[4] = '{4'b0110, 3,    20,   1'b0, 0,    4'b0010, 1'b0, 2'd0, 4'd0, "multi_hot"};
        tbl[5] = '{4'b0000, 3,    20,   1'b0, 0,    4'b0010, 1'b0, 2'd0, 4'd0, "zero_req"};

        reset         = 1'b1;
        motor_control = 4'b0000;
        drop_sensor   = 1'b0;
        restock_load  = 1'b0;
        restock_slot  = 2'd0;
        restock_count = 4'd0;
        repeat (2) tick();
        check("reset motor_drive", int'(motor_drive), 0);
        check("reset item_dispensed", int'(item_dispensed), 0);
        check("reset jam_fault", int'(jam_fault), 0);
        check("reset busy", int'(busy), 0);
        check("reset out_of_stock", int'(out_of_stock), 0);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].pre_rs) begin
                pulse_restock(tbl[i].rs_slot, tbl[i].rs_cnt);
                check({tbl[i].name, " restock oos"}, int'(out_of_stock), 0);
            end
            if (tbl[i].accept) begin
                run_vend(tbl[i].name, tbl[i].mc, tbl[i].k, tbl[i].budget, tbl[i].exp_drive,
                         tbl[i].exp_oos, -10, 2'd0, 4'd0);
            end else begin
                run_ignored(tbl[i].name, tbl[i].mc, tbl[i].k, tbl[i].budget);
                check({tbl[i].name, " out_of_stock"}, int'(out_of_stock), int'(tbl[i].exp_oos));
            end
        end

        // Restock of slot 0 lands on the same edge that enters DONE: stock[0] must become 5.
        run_vend("race", 4'b0001, 5, 50, 8, 4'b0010, 5 + 3, 2'd0, 4'd5);
        for (int i = 0; i < 5; i++) begin
            run_vend("drain0", 4'b0001, 2, 30, 5, (i == 4) ? 4'b0011 : 4'b0010, -10, 2'd0, 4'd0);
        end
        run_ignored("slot0_empty", 4'b0001, 3, 10);

        // Jam: no sensor activity at all.
        jam_n     = -1;
        jam_drive = 0;
        motor_control = 4'b1000;
        for (int n = 1; n <= 5100; n++) begin
            tick();
            if (motor_drive == 4'b1000) jam_drive++;
            if (jam_fault) begin
                jam_n = n;
                break;
            end
        end
        check("jam cycle", jam_n, 1 + 1000 + 4000);
        check("jam drive cycles", jam_drive, 1000);
        check("jam motor off", int'(motor_drive), 0);
        check("jam busy", int'(busy), 1);
        motor_control = 4'b0000;
        tick();
        motor_control = 4'b0100;
        repeat (5) tick();
        check("jam ignores request", int'(motor_drive), 0);
        check("jam held", int'(jam_fault), 1);
        motor_control = 4'b0000;
        pulse_restock(2'd3, 4'd9);
        tick();
        check("jam survives restock", int'(jam_fault), 1);
        reset = 1'b1;
        #1;
        check("reset clears jam", int'(jam_fault), 0);
        tick();
        reset = 1'b0;
        tick();

        // Reset mid-RUN: motor stops without a clock edge and stock returns to 8.
        run_vend("pre_reset", 4'b0100, 2, 30, 5, 4'b0000, -10, 2'd0, 4'd0);
        motor_control = 4'b0100;
        repeat (10) tick();
        check("mid-run drive", int'(motor_drive), 4);
        #2;
        reset = 1'b1;
        #1;
        check("async reset motor off", int'(motor_drive), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset oos", int'(out_of_stock), 0);
        motor_control = 4'b0000;
        #2;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            run_vend("drain2", 4'b0100, 2, 30, 5, (i == 7) ? 4'b0100 : 4'b0000, -10, 2'd0, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
